// File: rtl/dmem_responder.sv
// Word-organised data memory for the MEM stage with a request/response handshake,
// programmable wait states, pipeline stall and a saturating error counter.
module dmem_responder #(
    parameter int unsigned ADDR_BITS   = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_stall,
    output logic [7:0]  err_count
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ERRC_W    = 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
    localparam int unsigned WAIT_INIT = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [CNT_W-1:0]       waitCnt;
    logic                   latWe;
    logic                   latErr;
    logic [ADDR_BITS-1:0]   latIdx;
    logic [DATA_W-1:0]      latWdata;
    logic [DATA_W-1:0]      mem [DEPTH];

    logic                   accept;
    logic                   enterResp;
    logic                   reqErr;
    logic [ADDR_BITS-1:0]   reqIdx;
    logic                   accWe;
    logic                   accErr;
    logic [ADDR_BITS-1:0]   accIdx;
    logic [DATA_W-1:0]      accWdata;

    assign reqIdx = req_addr[ADDR_BITS+1:2];
    assign reqErr = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_BITS + 2)) != '0);

    // Next state, handshake and stall; the access operands come straight from the
    // request when RESP is entered directly from IDLE (zero wait states).
    always_comb begin
        stateNext = state;
        req_ready = (state == IDLE) && !reset;
        mem_stall = ((state == IDLE) && req_valid) || (state == WAIT);
        accept    = req_valid && req_ready;
        accWe     = latWe;
        accErr    = latErr;
        accIdx    = latIdx;
        accWdata  = latWdata;
        if (state == IDLE) begin
            accWe    = req_we;
            accErr   = reqErr;
            accIdx   = reqIdx;
            accWdata = req_wdata;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) stateNext = RESP;
                    else                  stateNext = WAIT;
                end
            end
            WAIT:    if (waitCnt == '0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        enterResp = (stateNext == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= stateNext;
            rsp_valid <= enterResp;
            if (accept) begin
                latWe    <= req_we;
                latErr   <= reqErr;
                latIdx   <= reqIdx;
                latWdata <= req_wdata;
                waitCnt  <= CNT_W'(WAIT_INIT);
            end else if ((state == WAIT) && (waitCnt != '0)) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (enterResp) begin
                rsp_err   <= accErr;
                rsp_rdata <= (accWe || accErr) ? '0 : mem[accIdx];
            end
            if ((state == RESP) && latErr && (err_count != '1)) begin
                err_count <= err_count + ERRC_W'(1);
            end
        end
    end

    // Storage is never cleared; a store lands only on a clean entry into RESP.
    always_ff @(posedge clk) begin
        if (!reset && enterResp && accWe && !accErr) begin
            mem[accIdx] <= accWdata;
        end
    end

endmodule
